// File: rtl/ddr_region_loader_pkg.sv
// Shared definitions for the DDR region loader: FSM state encoding, default DDR offset
// and small width helpers used by the top level and the bench.
package ddr_region_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STREAM = 3'd2,
      S_NEXT   = 3'd3,
      S_DONE   = 3'd4
   } loader_state_t;

   localparam logic [31:0] DDR_OFFSET_DEFAULT = 32'h0800_0000;

   // Bytes carried by one port word.
   function automatic int bpw(input int port_w, input int lane_w);
      return port_w / lane_w;
   endfunction

   // Index width that stays legal for a single-region build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr_region_loader_if.sv
// Source-word and DDR-write channels of the region loader, bundled with loader/environment modports.
interface ddr_region_loader_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int PORT_DATAWIDTH = 128
);

   // Both channels are valid/ready: a transfer happens on a clock edge where valid and ready are
   // both high; once valid is raised, it and its payload stay unchanged until that transfer.
   logic                      in_valid;
   logic [PORT_DATAWIDTH-1:0] in_data;
   logic                      in_ready;
   logic                      wr_valid;
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [PORT_DATAWIDTH-1:0] wr_data;
   logic                      wr_ready;

   modport master (
      input  in_valid, in_data, wr_ready,
      output in_ready, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output in_valid, in_data, wr_ready,
      input  in_ready, wr_valid, wr_addr, wr_data
   );

endinterface

// File: rtl/ddr_loader_outreg.sv
// One-entry valid/ready output register for DDR write requests; payload is held while stalled.
module ddr_loader_outreg #(
   parameter int AW = 32,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   output logic          can_load,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
);

   // Empty, or draining this cycle, so a new word can replace the current one.
   assign can_load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_addr  <= load_addr;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ddr_region_loader.sv
// DDR preload engine: streams host words into NUM_REGION DDR regions, one region at a time.
// Defining DDR_LOADER_CHECKSUM_EN adds a per-region lane checksum (chk_sum / chk_valid).
module ddr_region_loader
   import ddr_region_loader_pkg::*;
#(
   parameter int NUM_REGION     = 5,
   parameter int ADDR_WIDTH     = 32,
   parameter int PORT_DATAWIDTH = 128,
   parameter int DATA_WIDTH     = 8,
   parameter int LEN_WIDTH      = 20,
   parameter logic [ADDR_WIDTH-1:0] DDR_OFFSET = ADDR_WIDTH'(DDR_OFFSET_DEFAULT),
   localparam int IDX_W = idx_width(NUM_REGION)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [NUM_REGION*ADDR_WIDTH-1:0] region_base,
   input  logic [NUM_REGION*LEN_WIDTH-1:0]  region_len,
   ddr_region_loader_if.master              bus,
   output logic                             busy,
   output logic                             done,
   output logic [IDX_W-1:0]                 region_idx,
   output loader_state_t                    dbg_state
`ifdef DDR_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]                      chk_sum,
   output logic                             chk_valid
`endif
);

   localparam int BPW = bpw(PORT_DATAWIDTH, DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPW);
   localparam logic [IDX_W-1:0]      LAST_R    = IDX_W'(NUM_REGION - 1);
   localparam logic [LEN_WIDTH-1:0]  ONE       = LEN_WIDTH'(1);

   loader_state_t         state;
   logic [IDX_W-1:0]      r;
   logic [ADDR_WIDTH-1:0] base_q [NUM_REGION];
   logic [LEN_WIDTH-1:0]  len_q  [NUM_REGION];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  in_cnt;
   logic [LEN_WIDTH-1:0]  wr_cnt;
   logic [LEN_WIDTH-1:0]  cur_len;
   logic                  can_load;
   logic                  in_fire;
   logic                  wr_fire;

   assign cur_len    = len_q[r];
   assign region_idx = r;
   assign dbg_state  = state;

   // Accept only in STREAM, only until the region's word count is reached, only if the
   // output register can take the word.
   assign bus.in_ready = (state == S_STREAM) && (in_cnt != cur_len) && can_load;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign wr_fire      = bus.wr_valid && bus.wr_ready;

   ddr_loader_outreg #(
      .AW (ADDR_WIDTH),
      .DW (PORT_DATAWIDTH)
   ) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (in_fire),
      .load_addr (addr_q),
      .load_data (bus.in_data),
      .can_load  (can_load),
      .out_valid (bus.wr_valid),
      .out_addr  (bus.wr_addr),
      .out_data  (bus.wr_data),
      .out_ready (bus.wr_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         r      <= '0;
         addr_q <= '0;
         in_cnt <= '0;
         wr_cnt <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         for (int i = 0; i < NUM_REGION; i++) begin
            base_q[i] <= '0;
            len_q[i]  <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_REGION; i++) begin
                     base_q[i] <= region_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                     len_q[i]  <= region_len[i*LEN_WIDTH +: LEN_WIDTH];
                  end
                  r     <= '0;
                  busy  <= 1'b1;
                  state <= S_SETUP;
               end
            end
            S_SETUP: begin
               in_cnt <= '0;
               wr_cnt <= '0;
               addr_q <= base_q[r] - DDR_OFFSET;
               state  <= (cur_len == '0) ? S_NEXT : S_STREAM;
            end
            S_STREAM: begin
               if (in_fire) begin
                  addr_q <= addr_q + ADDR_STEP;
                  in_cnt <= in_cnt + ONE;
               end
               // The region ends on the handshake of its last word, not on its acceptance.
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + ONE;
                  if (wr_cnt == cur_len - ONE) state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (r == LAST_R) begin
                  state <= S_DONE;
               end else begin
                  r     <= r + IDX_W'(1);
                  state <= S_SETUP;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DDR_LOADER_CHECKSUM_EN
   logic [31:0] lane_sum;

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < BPW; i++) begin
         lane_sum = lane_sum + 32'(bus.wr_data[DATA_WIDTH*i +: DATA_WIDTH]);
      end
   end

   // Summed on the write handshake so only words that actually reached DDR are counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_sum <= '0;
      end else if (state == S_SETUP) begin
         chk_sum <= '0;
      end else if (state == S_STREAM && wr_fire) begin
         chk_sum <= chk_sum + lane_sum;
      end
   end

   assign chk_valid = (state == S_NEXT);
`endif

endmodule

// File: tb/tb_ddr_region_loader.sv
// Randomized bench for ddr_region_loader: a region-level model predicts every DDR write
// (region, address, data) and a scoreboard compares it against the write port.
module tb_ddr_region_loader;
   import ddr_region_loader_pkg::*;

   localparam int NR    = 5;
   localparam int AW    = 32;
   localparam int PDW   = 128;
   localparam int DW    = 8;
   localparam int LW    = 20;
   localparam int BPW   = PDW / DW;
   localparam int IW    = 3;
   localparam int EXP_W = IW + AW + PDW;
   localparam logic [AW-1:0] OFF = 32'h0800_0000;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [NR*AW-1:0] region_base;
   logic [NR*LW-1:0] region_len;
   logic busy, done;
   logic [IW-1:0] region_idx;
   loader_state_t dbg_state;
`ifdef DDR_LOADER_CHECKSUM_EN
   logic [31:0] chk_sum;
   logic chk_valid;
`endif

   always #5 clk = ~clk;

   ddr_region_loader_if #(.ADDR_WIDTH(AW), .PORT_DATAWIDTH(PDW)) bus_if ();

   ddr_region_loader #(
      .NUM_REGION(NR), .ADDR_WIDTH(AW), .PORT_DATAWIDTH(PDW),
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DDR_OFFSET(OFF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .region_base (region_base),
      .region_len  (region_len),
      .bus         (bus_if),
      .busy        (busy),
      .done        (done),
      .region_idx  (region_idx),
      .dbg_state   (dbg_state)
`ifdef DDR_LOADER_CHECKSUM_EN
      ,
      .chk_sum     (chk_sum),
      .chk_valid   (chk_valid)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   logic [PDW-1:0]   src_q[$];
   logic [31:0]      chk_q[$];
   int               wr_t[$];
   int               in_t[$];
   logic [AW-1:0]    tb_base [NR];
   logic [LW-1:0]    tb_len  [NR];
   int n_checks = 0;
   int n_fail   = 0;
   int wr_count, done_count, total_words, cyc_now;
   int rdy_mode, valid_pct, fill_mode;

   task automatic check(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Region r, word k lands at base[r] - OFF + k*BPW and carries the next source word in order.
   task automatic start_load();
      logic [PDW-1:0] w;
      logic [31:0] s;
      exp_q.delete(); src_q.delete(); chk_q.delete(); wr_t.delete(); in_t.delete();
      wr_count = 0; done_count = 0; total_words = 0;
      for (int r = 0; r < NR; r++) begin
         s = 0;
         for (int k = 0; k < int'(tb_len[r]); k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if (fill_mode == 1 && total_words == 0) w = 128'h0102030405060708090a0b0c0d0e0f10;
            if (fill_mode == 2) w = '1;
            for (int b = 0; b < BPW; b++) s = s + 32'(w[b*DW +: DW]);
            src_q.push_back(w);
            exp_q.push_back({IW'(r), tb_base[r] - OFF + AW'(k * BPW), w});
            total_words++;
         end
         chk_q.push_back(s);
      end
      for (int r = 0; r < NR; r++) begin
         region_base[r*AW +: AW] = tb_base[r];
         region_len[r*LW +: LW]  = tb_len[r];
      end
      start = 1'b1;
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b0;
      region_base = {NR{$urandom}};
      region_len  = {NR{20'hfffff}};
      check("busy_on_start", busy, 1);
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) start = 1'b1;
         if (cyc == 3) start = 1'b0;
         if (done) break;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic finish_checks(input string tag);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_exp_empty"}, exp_q.size(), 0);
      check({tag, "_writes"}, wr_count, total_words);
      check({tag, "_in_words"}, in_t.size(), total_words);
      check({tag, "_done_once"}, done_count, 1);
      check({tag, "_busy_clear"}, busy, 0);
      check({tag, "_in_ready_idle"}, bus_if.in_ready, 0);
   endtask

   // Bus agent: monitors at negedge, drives source and sink just after posedge.
   initial begin : agent
      logic in_hs, wr_hs, stalled;
      logic [AW-1:0]    st_addr;
      logic [PDW-1:0]   st_data;
      logic [EXP_W-1:0] e;
      stalled = 1'b0;
      cyc_now = 0;
      forever begin
         @(negedge clk);
         in_hs = bus_if.in_valid && bus_if.in_ready;
         wr_hs = bus_if.wr_valid && bus_if.wr_ready;
         if (rst_n) begin
            if (stalled) begin
               check("stall_valid", bus_if.wr_valid, 1);
               check("stall_addr", bus_if.wr_addr, st_addr);
               check("stall_data", bus_if.wr_data, st_data);
            end
            if (wr_hs) begin
               if (exp_q.size() == 0) check("extra_write", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("wr_region", region_idx, e[EXP_W-1 -: IW]);
                  check("wr_addr", bus_if.wr_addr, e[PDW +: AW]);
                  check("wr_data", bus_if.wr_data, e[PDW-1:0]);
               end
               wr_count++;
               wr_t.push_back(cyc_now);
            end
            if (in_hs) in_t.push_back(cyc_now);
            if (done) done_count++;
`ifdef DDR_LOADER_CHECKSUM_EN
            if (chk_valid) begin
               if (chk_q.size() == 0) check("chk_extra", 1, 0);
               else check("chk_sum", chk_sum, chk_q.pop_front());
            end
`endif
            stalled = bus_if.wr_valid && !bus_if.wr_ready;
            st_addr = bus_if.wr_addr;
            st_data = bus_if.wr_data;
         end else begin
            stalled = 1'b0;
         end
         @(posedge clk); #1;
         cyc_now++;
         if (in_hs && rst_n && src_q.size() > 0) void'(src_q.pop_front());
         case (rdy_mode)
            0: bus_if.wr_ready = 1'b1;
            1: bus_if.wr_ready = 1'($urandom_range(0, 1));
            2: bus_if.wr_ready = !bus_if.wr_ready;
            default: bus_if.wr_ready = 1'b0;
         endcase
         bus_if.in_valid = (src_q.size() > 0) && ($urandom_range(1, 100) <= valid_pct);
         bus_if.in_data  = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // ---------------- test sequence ----------------
   initial begin : main
      int cyc;
      rst_n = 1'b0; start = 1'b0; region_base = '0; region_len = '0;
      bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.wr_ready = 1'b0;
      rdy_mode = 0; valid_pct = 100; fill_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_valid", bus_if.wr_valid, 0);
      check("rst_wr_addr", bus_if.wr_addr, 0);
      check("rst_in_ready", bus_if.in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_region_idx", region_idx, 0);
      check("rst_state", dbg_state, S_IDLE);
      #1 rst_n = 1'b1;

      // Single word at offset zero, then four back-to-back words.
      tb_base = '{32'h0800_0000, 32'h0810_0000, 32'h0900_0000, 32'h0A00_0000, 32'h0B00_0000};
      tb_len  = '{20'd1, 20'd4, 20'd0, 20'd0, 20'd0};
      fill_mode = 1;
      start_load();
      pulse_start();
      wait_done(400, cyc);
      finish_checks("t1");
      check("t1_first_latency", wr_t[0] - in_t[0], 1);
      check("t2_back_to_back", wr_t[4] - wr_t[1], 3);
      fill_mode = 0;

      // Sink held off, then toggling: nothing lost, payload stable while stalled.
      tb_len  = '{20'd2, 20'd6, 20'd0, 20'd0, 20'd0};
      rdy_mode = 3;
      start_load();
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      check("t3_stall_no_write", wr_count, 0);
      check("t3_stall_valid", bus_if.wr_valid, 1);
      rdy_mode = 2;
      wait_done(400, cyc);
      finish_checks("t3");

      // Skipped regions.
      tb_base = '{32'h0800_1000, 32'h0800_2000, 32'h0C00_0000, 32'h0800_3000, 32'h0D00_0100};
      tb_len  = '{20'd0, 20'd0, 20'd3, 20'd0, 20'd2};
      rdy_mode = 1; valid_pct = 70;
      start_load();
      pulse_start();
      wait_done(600, cyc);
      finish_checks("t4");

      // All lengths zero: done exactly 2*NR+2 cycles after the start cycle.
      tb_len  = '{20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
      start_load();
      pulse_start();
      wait_done(100, cyc);
      check("t0_done_latency", 1 + cyc, 2 * NR + 2);
      finish_checks("t0");

      // Reset in the middle of a region, then a fresh load.
      tb_base = '{32'h0820_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000};
      tb_len  = '{20'd4, 20'd0, 20'd0, 20'd0, 20'd0};
      rdy_mode = 0; valid_pct = 100;
      start_load();
      pulse_start();
      cyc = 0;
      while (wr_count < 2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check("t5_reached_two", wr_count >= 2, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_wr_valid", bus_if.wr_valid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_in_ready", bus_if.in_ready, 0);
      check("t5_rst_state", dbg_state, S_IDLE);
      exp_q.delete(); src_q.delete();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t5_no_done", done_count, 0);
      start_load();
      pulse_start();
      wait_done(400, cyc);
      finish_checks("t5");

      // Randomized regions, bases (including address wrap) and handshake pressure.
      for (int it = 0; it < 6; it++) begin
         for (int r = 0; r < NR; r++) begin
            tb_base[r] = $urandom & 32'hFFFF_FFF0;
            tb_len[r]  = LW'($urandom_range(0, 5));
         end
         if (it == 0) tb_base[0] = OFF - 32'h20;
         rdy_mode  = $urandom_range(0, 2);
         valid_pct = $urandom_range(50, 100);
         start_load();
         pulse_start();
         wait_done(2000, cyc);
         finish_checks("rand");
      end

`ifdef DDR_LOADER_CHECKSUM_EN
      tb_base = '{32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000};
      tb_len  = '{20'd1, 20'd0, 20'd0, 20'd0, 20'd0};
      fill_mode = 2; rdy_mode = 0; valid_pct = 100;
      start_load();
      check("t6_model_sum", chk_q[0], 32'h0000_0FF0);
      pulse_start();
      wait_done(200, cyc);
      finish_checks("t6");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
